// File: rtl/glb_arbiter_if.sv
// Bus bundle between the GLB arbiter, its read/write clients and the GLB macro.
// The arbiter takes the slave modport; clients and the GLB model take the master modport.
interface glb_arbiter_if #(
    parameter int NUM_RD     = 4,
    parameter int NUM_WR     = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 8,
    parameter int DATA_WIDTH = 32
);
    localparam int ID_W = $clog2(NUM_RD);

    logic [NUM_RD-1:0]            rd_req_valid;
    logic [NUM_RD*ADDR_WIDTH-1:0] rd_req_addr;
    logic [NUM_RD*LEN_WIDTH-1:0]  rd_req_len;
    logic [NUM_RD-1:0]            rd_req_ready;
    logic                         rd_rsp_valid;
    logic [ID_W-1:0]              rd_rsp_id;
    logic [DATA_WIDTH-1:0]        rd_rsp_data;
    logic                         rd_rsp_last;
    logic [NUM_WR-1:0]            wr_valid;
    logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr;
    logic [NUM_WR*DATA_WIDTH-1:0] wr_data;
    logic [NUM_WR-1:0]            wr_ready;
    logic                         glb_re;
    logic [ADDR_WIDTH-1:0]        glb_r_addr;
    logic [DATA_WIDTH-1:0]        glb_dout;
    logic                         glb_we;
    logic [ADDR_WIDTH-1:0]        glb_w_addr;
    logic [DATA_WIDTH-1:0]        glb_din;

    modport slave (
        input  rd_req_valid, rd_req_addr, rd_req_len, wr_valid, wr_addr, wr_data, glb_dout,
        output rd_req_ready, rd_rsp_valid, rd_rsp_id, rd_rsp_data, rd_rsp_last, wr_ready,
               glb_re, glb_r_addr, glb_we, glb_w_addr, glb_din
    );

    modport master (
        output rd_req_valid, rd_req_addr, rd_req_len, wr_valid, wr_addr, wr_data, glb_dout,
        input  rd_req_ready, rd_rsp_valid, rd_rsp_id, rd_rsp_data, rd_rsp_last, wr_ready,
               glb_re, glb_r_addr, glb_we, glb_w_addr, glb_din
    );
endinterface

// File: rtl/glb_arbiter.sv
// Round-robin arbiter for the GLB: burst reads sequenced one word per cycle,
// single-word writes granted per cycle. Read and write sides run independently.
module glb_arbiter #(
    parameter int NUM_RD     = 4,
    parameter int NUM_WR     = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 8,
    parameter int DATA_WIDTH = 32
) (
    input logic          clk,
    input logic          rst,
    glb_arbiter_if.slave bus
);
    // state | meaning
    // IDLE  | waiting for a read request; grants and latches it, no GLB read issued
    // BURST | one glb_re per cycle at the latched address until the word count runs out
    localparam int ID_W  = $clog2(NUM_RD);
    localparam int WID_W = $clog2(NUM_WR);

    typedef enum logic {IDLE, BURST} rd_state_e;

    rd_state_e             state_q, state_d;
    logic [ID_W-1:0]       rd_ptr_q, rd_ptr_d, rd_id_q, rd_id_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [LEN_WIDTH-1:0]  rd_cnt_q, rd_cnt_d;
    logic                  rsp_valid_q, rsp_last_q;
    logic [ID_W-1:0]       rsp_id_q;
    logic [WID_W-1:0]      wr_ptr_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] w_addr_q;
    logic [DATA_WIDTH-1:0] din_q;

    logic                  rd_found, wr_found, re_c, last_c;
    logic [ID_W-1:0]       rd_gnt;
    logic [WID_W-1:0]      wr_gnt;
    logic [NUM_RD-1:0]     rd_ready_c;
    logic [NUM_WR-1:0]     wr_ready_c;

    // First valid client at or after the pointer, wrapping without needing a power-of-two count.
    always_comb begin : rd_pick
        logic [ID_W:0] sum;
        rd_found = 1'b0;
        rd_gnt   = '0;
        sum      = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            sum = {1'b0, rd_ptr_q} + (ID_W+1)'(i);
            if (sum >= (ID_W+1)'(NUM_RD)) sum = sum - (ID_W+1)'(NUM_RD);
            if (!rd_found && bus.rd_req_valid[sum[ID_W-1:0]]) begin
                rd_found = 1'b1;
                rd_gnt   = sum[ID_W-1:0];
            end
        end
    end

    always_comb begin : wr_pick
        logic [WID_W:0] sum;
        wr_found = 1'b0;
        wr_gnt   = '0;
        sum      = '0;
        for (int i = 0; i < NUM_WR; i++) begin
            sum = {1'b0, wr_ptr_q} + (WID_W+1)'(i);
            if (sum >= (WID_W+1)'(NUM_WR)) sum = sum - (WID_W+1)'(NUM_WR);
            if (!wr_found && bus.wr_valid[sum[WID_W-1:0]]) begin
                wr_found = 1'b1;
                wr_gnt   = sum[WID_W-1:0];
            end
        end
        wr_ready_c = '0;
        if (wr_found) wr_ready_c[wr_gnt] = 1'b1;
    end

    always_comb begin : rd_fsm
        state_d    = state_q;
        rd_ptr_d   = rd_ptr_q;
        rd_id_d    = rd_id_q;
        rd_addr_d  = rd_addr_q;
        rd_cnt_d   = rd_cnt_q;
        rd_ready_c = '0;
        re_c       = 1'b0;
        last_c     = 1'b0;
        case (state_q)
            IDLE: begin
                if (rd_found) begin
                    rd_ready_c[rd_gnt] = 1'b1;
                    rd_id_d   = rd_gnt;
                    rd_addr_d = bus.rd_req_addr[rd_gnt*ADDR_WIDTH +: ADDR_WIDTH];
                    rd_cnt_d  = bus.rd_req_len[rd_gnt*LEN_WIDTH +: LEN_WIDTH];
                    rd_ptr_d  = (rd_gnt == ID_W'(NUM_RD-1)) ? '0 : rd_gnt + 1'b1;
                    state_d   = BURST;
                end
            end
            BURST: begin
                re_c      = 1'b1;
                rd_addr_d = rd_addr_q + ADDR_WIDTH'(4);
                if (rd_cnt_q == '0) begin
                    last_c  = 1'b1;
                    state_d = IDLE;
                end else begin
                    rd_cnt_d = rd_cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rd_ptr_q    <= '0;
            rd_id_q     <= '0;
            rd_addr_q   <= '0;
            rd_cnt_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            rsp_id_q    <= '0;
            wr_ptr_q    <= '0;
            we_q        <= 1'b0;
            w_addr_q    <= '0;
            din_q       <= '0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            rd_id_q     <= rd_id_d;
            rd_addr_q   <= rd_addr_d;
            rd_cnt_q    <= rd_cnt_d;
            rsp_valid_q <= re_c;
            rsp_last_q  <= last_c;
            rsp_id_q    <= rd_id_q;
            we_q        <= wr_found;
            if (wr_found) begin
                w_addr_q <= bus.wr_addr[wr_gnt*ADDR_WIDTH +: ADDR_WIDTH];
                din_q    <= bus.wr_data[wr_gnt*DATA_WIDTH +: DATA_WIDTH];
                wr_ptr_q <= (wr_gnt == WID_W'(NUM_WR-1)) ? '0 : wr_gnt + 1'b1;
            end
        end
    end

    // Combinational outputs are held low while rst is asserted so a mid-burst reset stops reads at once.
    assign bus.rd_req_ready = rst ? '0 : rd_ready_c;
    assign bus.wr_ready     = rst ? '0 : wr_ready_c;
    assign bus.glb_re       = re_c & ~rst;
    assign bus.glb_r_addr   = rst ? '0 : rd_addr_q;
    assign bus.rd_rsp_valid = rsp_valid_q;
    assign bus.rd_rsp_id    = rsp_id_q;
    assign bus.rd_rsp_last  = rsp_last_q;
    assign bus.rd_rsp_data  = bus.glb_dout;
    assign bus.glb_we       = we_q;
    assign bus.glb_w_addr   = w_addr_q;
    assign bus.glb_din      = din_q;
endmodule

// File: tb/tb_glb_arbiter.sv
// Directed bench for glb_arbiter with a small write-first GLB model and an event monitor.
module tb_glb_arbiter;
    localparam int NUM_RD = 4, NUM_WR = 2, AW = 32, LW = 8, DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    glb_arbiter_if #(.NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .ADDR_WIDTH(AW), .LEN_WIDTH(LW),
                     .DATA_WIDTH(DW)) u_if ();
    glb_arbiter #(.NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .ADDR_WIDTH(AW), .LEN_WIDTH(LW),
                  .DATA_WIDTH(DW)) dut (.clk(clk), .rst(rst), .bus(u_if));

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // GLB model: registered read, write-first on same-cycle address match.
    logic [31:0] mem [256];
    bit          written [256];
    always @(posedge clk) begin
        if (u_if.glb_we) begin
            mem[u_if.glb_w_addr[9:2]]     <= u_if.glb_din;
            written[u_if.glb_w_addr[9:2]] <= 1'b1;
        end
        if (u_if.glb_re) begin
            if (u_if.glb_we && u_if.glb_w_addr == u_if.glb_r_addr)
                u_if.glb_dout <= u_if.glb_din;
            else if (written[u_if.glb_r_addr[9:2]])
                u_if.glb_dout <= mem[u_if.glb_r_addr[9:2]];
            else
                u_if.glb_dout <= {24'hC0DE00, u_if.glb_r_addr[9:2]};
        end
    end

    logic [31:0] re_addr[$], rsp_data[$], we_addr[$], we_data[$];
    int          re_cyc[$], rsp_cyc[$], rsp_id[$], gnt_cyc[$], wgnt_cyc[$], we_cyc[$];
    bit          rsp_last[$];
    logic [3:0]  gnt[$];
    logic [1:0]  wgnt[$];

    always @(negedge clk) begin
        if (u_if.glb_re) begin re_addr.push_back(u_if.glb_r_addr); re_cyc.push_back(cyc); end
        if (u_if.rd_rsp_valid) begin
            rsp_data.push_back(u_if.rd_rsp_data); rsp_id.push_back(int'(u_if.rd_rsp_id));
            rsp_last.push_back(u_if.rd_rsp_last); rsp_cyc.push_back(cyc);
        end
        if (u_if.rd_req_ready != 0) begin gnt.push_back(u_if.rd_req_ready); gnt_cyc.push_back(cyc); end
        if (u_if.wr_ready != 0) begin wgnt.push_back(u_if.wr_ready); wgnt_cyc.push_back(cyc); end
        if (u_if.glb_we) begin
            we_addr.push_back(u_if.glb_w_addr); we_data.push_back(u_if.glb_din); we_cyc.push_back(cyc);
        end
    end

    task automatic clear_mon();
        re_addr.delete(); re_cyc.delete(); rsp_data.delete(); rsp_id.delete(); rsp_last.delete();
        rsp_cyc.delete(); gnt.delete(); gnt_cyc.delete(); wgnt.delete(); wgnt_cyc.delete();
        we_addr.delete(); we_data.delete(); we_cyc.delete();
    endtask

    task automatic zero_inputs();
        u_if.rd_req_valid = '0; u_if.rd_req_addr = '0; u_if.rd_req_len = '0;
        u_if.wr_valid = '0; u_if.wr_addr = '0; u_if.wr_data = '0;
    endtask

    task automatic do_reset();
        zero_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        clear_mon();
    endtask

    task automatic set_rd(input int c, input logic [31:0] a, input logic [7:0] l, input logic v);
        u_if.rd_req_valid[c]        = v;
        u_if.rd_req_addr[c*AW +: AW] = a;
        u_if.rd_req_len[c*LW +: LW]  = l;
    endtask

    // Returns on the negedge at which a read grant appears (or after the cycle budget).
    task automatic wait_rd_grant(input logic [3:0] exp, input string name);
        logic [3:0] seen;
        seen = '0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            seen = u_if.rd_req_ready;
            if (seen != 0) break;
        end
        checks++;
        if (seen !== exp) begin
            errors++;
            $display("FAIL %s: rd_req_ready got %b expected %b", name, seen, exp);
        end
    endtask

    task automatic test_reset();
        zero_inputs();
        rst = 1'b1;
        u_if.rd_req_valid = 4'b1111;
        u_if.wr_valid = 2'b11;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (u_if.rd_req_ready !== 4'b0) begin errors++; $display("FAIL rst_rd_ready: got %b expected 0000", u_if.rd_req_ready); end
        checks++; if (u_if.wr_ready !== 2'b0) begin errors++; $display("FAIL rst_wr_ready: got %b expected 00", u_if.wr_ready); end
        checks++; if (u_if.glb_re !== 1'b0) begin errors++; $display("FAIL rst_glb_re: got %b expected 0", u_if.glb_re); end
        checks++; if (u_if.glb_we !== 1'b0) begin errors++; $display("FAIL rst_glb_we: got %b expected 0", u_if.glb_we); end
        checks++; if (u_if.rd_rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b expected 0", u_if.rd_rsp_valid); end
        checks++; if (u_if.glb_w_addr !== 32'h0 || u_if.glb_din !== 32'h0) begin errors++; $display("FAIL rst_w_bus: got %h/%h expected 0/0", u_if.glb_w_addr, u_if.glb_din); end
        checks++; if (u_if.glb_r_addr !== 32'h0 || u_if.rd_rsp_last !== 1'b0 || u_if.rd_rsp_id !== 2'd0) begin errors++; $display("FAIL rst_rsp_bus: got %h/%b/%0d expected 0/0/0", u_if.glb_r_addr, u_if.rd_rsp_last, u_if.rd_rsp_id); end
        do_reset();
    endtask

    task automatic test_single_read();
        do_reset();
        set_rd(1, 32'h100, 8'd3, 1'b1);
        wait_rd_grant(4'b0010, "single_gnt");
        @(posedge clk); #1 set_rd(1, 32'h0, 8'd0, 1'b0);
        repeat (8) @(posedge clk); #1;
        checks++; if (re_addr.size() != 4) begin errors++; $display("FAIL single_re_count: got %0d expected 4", re_addr.size()); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (re_addr[k] !== 32'h100 + 32'(4*k)) begin errors++; $display("FAIL single_re_addr%0d: got %h expected %h", k, re_addr[k], 32'h100 + 32'(4*k)); end
        end
        checks++; if (re_cyc[0] != gnt_cyc[0] + 1 || re_cyc[3] != gnt_cyc[0] + 4) begin errors++; $display("FAIL single_re_timing: got %0d..%0d expected %0d..%0d", re_cyc[0], re_cyc[3], gnt_cyc[0]+1, gnt_cyc[0]+4); end
        checks++; if (rsp_data.size() != 4) begin errors++; $display("FAIL single_rsp_count: got %0d expected 4", rsp_data.size()); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (rsp_id[k] != 1 || rsp_last[k] != (k == 3) || rsp_data[k] !== 32'hC0DE0040 + 32'(k)) begin
                errors++;
                $display("FAIL single_rsp%0d: got id=%0d last=%0d data=%h expected id=1 last=%0d data=%h",
                         k, rsp_id[k], rsp_last[k], rsp_data[k], (k == 3), 32'hC0DE0040 + 32'(k));
            end
        end
        checks++; if (rsp_cyc[0] != re_cyc[0] + 1) begin errors++; $display("FAIL single_rsp_lat: got %0d expected %0d", rsp_cyc[0], re_cyc[0] + 1); end
    endtask

    task automatic test_rr_read();
        logic [3:0] r;
        do_reset();
        set_rd(0, 32'h10, 8'd0, 1'b1);
        set_rd(2, 32'h20, 8'd0, 1'b1);
        set_rd(3, 32'h30, 8'd0, 1'b1);
        for (int k = 0; k < 16 && u_if.rd_req_valid != 0; k++) begin
            @(negedge clk); r = u_if.rd_req_ready;
            @(posedge clk); #1 u_if.rd_req_valid = u_if.rd_req_valid & ~r;
        end
        repeat (4) @(posedge clk); #1;
        checks++; if (gnt.size() != 3) begin errors++; $display("FAIL rr_gnt_count: got %0d expected 3", gnt.size()); end
        checks++; if (gnt[0] !== 4'b0001 || gnt[1] !== 4'b0100 || gnt[2] !== 4'b1000) begin errors++; $display("FAIL rr_order: got %b %b %b expected 0001 0100 1000", gnt[0], gnt[1], gnt[2]); end
        checks++; if (gnt_cyc[1] != gnt_cyc[0] + 2 || gnt_cyc[2] != gnt_cyc[0] + 4) begin errors++; $display("FAIL rr_spacing: got +%0d +%0d expected +2 +4", gnt_cyc[1]-gnt_cyc[0], gnt_cyc[2]-gnt_cyc[0]); end
        checks++; if (re_addr.size() != 3 || re_addr[0] !== 32'h10 || re_addr[1] !== 32'h20 || re_addr[2] !== 32'h30) begin errors++; $display("FAIL rr_addrs: got n=%0d %h %h %h expected 10 20 30", re_addr.size(), re_addr[0], re_addr[1], re_addr[2]); end
    endtask

    task automatic test_fairness();
        do_reset();
        set_rd(0, 32'h0, 8'd0, 1'b1);
        set_rd(1, 32'h4, 8'd0, 1'b1);
        repeat (9) @(posedge clk);
        #1 u_if.rd_req_valid = '0;
        repeat (4) @(posedge clk); #1;
        checks++; if (gnt.size() < 4) begin errors++; $display("FAIL fair_count: got %0d expected at least 4", gnt.size()); end
        checks++;
        if (gnt[0] !== 4'b0001 || gnt[1] !== 4'b0010 || gnt[2] !== 4'b0001 || gnt[3] !== 4'b0010) begin
            errors++; $display("FAIL fair_order: got %b %b %b %b expected 0001 0010 0001 0010", gnt[0], gnt[1], gnt[2], gnt[3]);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        set_rd(2, 32'hFFFF_FFFC, 8'd1, 1'b1);
        wait_rd_grant(4'b0100, "wrap_gnt");
        @(posedge clk); #1 set_rd(2, 32'h0, 8'd0, 1'b0);
        repeat (6) @(posedge clk); #1;
        checks++; if (re_addr.size() != 2 || re_addr[0] !== 32'hFFFF_FFFC || re_addr[1] !== 32'h0) begin errors++; $display("FAIL wrap_addrs: got n=%0d %h %h expected fffffffc 00000000", re_addr.size(), re_addr[0], re_addr[1]); end
        checks++; if (rsp_data.size() != 2 || rsp_last[0] != 1'b0 || rsp_last[1] != 1'b1 || rsp_id[1] != 2) begin errors++; $display("FAIL wrap_rsp: got n=%0d last=%0d%0d id=%0d expected n=2 last=01 id=2", rsp_data.size(), rsp_last[0], rsp_last[1], rsp_id[1]); end
        checks++; if (rsp_data[0] !== 32'hC0DE00FF || rsp_data[1] !== 32'hC0DE0000) begin errors++; $display("FAIL wrap_data: got %h %h expected c0de00ff c0de0000", rsp_data[0], rsp_data[1]); end
    endtask

    task automatic test_writes();
        logic [31:0] ea, ed;
        do_reset();
        @(posedge clk); #1;
        u_if.wr_addr = {32'h44, 32'h40};
        u_if.wr_data = {32'h1234_5678, 32'hDEAD_BEEF};
        u_if.wr_valid = 2'b11;
        repeat (4) @(posedge clk);
        #1 u_if.wr_valid = 2'b00;
        repeat (3) @(posedge clk); #1;
        checks++; if (wgnt.size() != 4 || we_addr.size() != 4) begin errors++; $display("FAIL wr_count: got grants=%0d we=%0d expected 4/4", wgnt.size(), we_addr.size()); end
        for (int k = 0; k < 4; k++) begin
            ea = (k % 2 == 0) ? 32'h40 : 32'h44;
            ed = (k % 2 == 0) ? 32'hDEAD_BEEF : 32'h1234_5678;
            checks++;
            if (wgnt[k] !== ((k % 2 == 0) ? 2'b01 : 2'b10) || we_addr[k] !== ea || we_data[k] !== ed || we_cyc[k] != wgnt_cyc[k] + 1) begin
                errors++;
                $display("FAIL wr_beat%0d: got gnt=%b addr=%h data=%h dly=%0d expected gnt=%b addr=%h data=%h dly=1",
                         k, wgnt[k], we_addr[k], we_data[k], we_cyc[k] - wgnt_cyc[k], (k % 2 == 0) ? 2'b01 : 2'b10, ea, ed);
            end
        end
        clear_mon();
        set_rd(3, 32'h40, 8'd0, 1'b1);
        wait_rd_grant(4'b1000, "wr_rd_gnt");
        @(posedge clk); #1 set_rd(3, 32'h0, 8'd0, 1'b0);
        repeat (4) @(posedge clk); #1;
        checks++; if (rsp_data.size() != 1 || rsp_data[0] !== 32'hDEAD_BEEF || rsp_id[0] != 3 || rsp_last[0] != 1'b1) begin errors++; $display("FAIL wr_readback: got n=%0d data=%h id=%0d expected n=1 data=deadbeef id=3", rsp_data.size(), rsp_data[0], rsp_id[0]); end
    endtask

    task automatic test_reset_mid_burst();
        int n;
        do_reset();
        set_rd(0, 32'h200, 8'd7, 1'b1);
        wait_rd_grant(4'b0001, "abort_gnt");
        @(posedge clk); #1 set_rd(0, 32'h0, 8'd0, 1'b0);
        n = 0;
        for (int k = 0; k < 20 && n < 3; k++) begin
            @(negedge clk);
            if (u_if.glb_re) n++;
        end
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (u_if.glb_re !== 1'b0 || u_if.rd_rsp_valid !== 1'b0) begin errors++; $display("FAIL abort_quiet%0d: got re=%b rsp=%b expected 0/0", k, u_if.glb_re, u_if.rd_rsp_valid); end
        end
        checks++; if (re_addr.size() != 3 || rsp_data.size() != 2) begin errors++; $display("FAIL abort_counts: got re=%0d rsp=%0d expected 3/2", re_addr.size(), rsp_data.size()); end
        clear_mon();
        @(posedge clk); #1 set_rd(0, 32'h300, 8'd0, 1'b1);
        wait_rd_grant(4'b0001, "abort_regnt");
        @(posedge clk); #1 set_rd(0, 32'h0, 8'd0, 1'b0);
        repeat (4) @(posedge clk); #1;
        checks++; if (re_addr.size() != 1 || re_addr[0] !== 32'h300 || gnt_cyc.size() != 1 || re_cyc[0] != gnt_cyc[0] + 1) begin errors++; $display("FAIL abort_rerequest: got n=%0d addr=%h expected n=1 addr=00000300", re_addr.size(), re_addr[0]); end
    endtask

    initial begin
        zero_inputs();
        test_reset();
        test_single_read();
        test_rr_read();
        test_fairness();
        test_wrap();
        test_writes();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
